exec_addx_seq: RTL and testbench
================================

Name: exec_addx_seq

Overview:
- Multi-precision add/subtract sequencer built around the exec_addx single-word adder.
- Accepts one request (add or sub, N words), then consumes N operand word pairs, least-significant first.
- Chains carry/borrow between words and streams out N result words.
- Posts final {overflow, sign, zero, carry} flags for the whole multi-word result; sits in the execute stage beside the ALU, feeding the flags register.

Parameters:
- W_OPR, 32, operand/result word width (shared package value).
- W_FLAGS, 4, flags width, ordered {V, S, Z, C}.
- W_CNT, 4, width of the word-count field; max operation length 2^W_CNT - 1 words.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid_i  in  1  request offered.
- req_ready_o  out  1  high only in IDLE.
- req_sub_i  in  1  0 = add (A+B), 1 = subtract (A-B).
- req_nwords_i  in  W_CNT  number of words; 0 is treated as 1.
- opr_valid_i  in  1  operand pair offered.
- opr_ready_o  out  1  operand pair accepted when valid & ready.
- opr0_i  in  W_OPR  A word.
- opr1_i  in  W_OPR  B word.
- res_valid_o  out  1  result word valid.
- res_ready_i  in  1  consumer accepts the result word.
- res_o  out  W_OPR  result word.
- res_last_o  out  1  marks the most-significant result word.
- done_o  out  1  one-cycle pulse once the last result word is accepted.
- flags_o  out  W_FLAGS  final flags; held stable from the done_o pulse until the next request is accepted.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, res_valid_o=0, res_o=0, res_last_o=0, done_o=0, flags_o=0, carry register=0, word counter=0.
- Reset mid-operation aborts the operation: the partial result is discarded and no done_o pulse is issued.
- States:
  - IDLE: req_ready_o=1. A request handshake latches sub, remaining=max(nwords,1), carry-in=sub, zacc=1, then moves to RUN.
  - RUN: opr_ready_o = ~res_valid_o | res_ready_i (one-entry output register, full throughput).
    - On each operand handshake, exec_addx is driven with select={1,sub} and flags_i[0]=cin^sub, so cin is 0 for the first add word, 1 for the first sub word, and the previous carry-out afterwards.
    - Registered outputs: res_o; res_last_o=(remaining==1); carry register <= carry-out; zacc <= zacc & Z_word; remaining decrements.
    - The last handshake stores V and S from that word, C = final carry-out (sub: 1 = no borrow), Z = zacc & Z_word, then moves to DRAIN.
  - DRAIN: opr_ready_o=0. When the last word is accepted (res_valid_o & res_ready_i & res_last_o): flags_o updates, done_o=1 for one cycle, state returns to IDLE.
- Result-register rules:
  - res_valid_o clears on a consumer handshake with no new word.
  - A simultaneous consume and new operand reloads the register in the same cycle with no bubble.
- Latency: 1 cycle from operand handshake to res_valid_o; done_o comes in the cycle after the last result handshake.
- Arithmetic: each word is computed on W_OPR bits with the carry taken from bit W_OPR. V uses two's-complement rules on the top word only.
- Ignored inputs: req_valid_i outside IDLE, and opr_valid_i outside RUN, are ignored and their data dropped.

Decomposition:
- Shared package/params include: W_OPR, W_FLAGS, flag bit indices (FLAG_C=0, FLAG_Z=1, FLAG_S=2, FLAG_V=3), and state encodings (ST_IDLE, ST_RUN, ST_DRAIN).
- One sub-module: exec_addx, instantiated unchanged as the word adder. All sequencing, carry and zero accumulation live in this block.

Test Plan:
- Two-word add: A=0x00000001_FFFFFFFF, B=0x00000000_00000001 -> res 0x00000000 then 0x00000002 (last), flags V=0 S=0 Z=0 C=0, done_o one pulse.
- Two-word sub with equal operands, A=B=0x12345678_9ABCDEF0 -> both words 0x00000000, Z=1, C=1, S=0, V=0.
- One-word add 0x7FFFFFFF+0x00000001 -> res 0x80000000, V=1, S=1, Z=0, C=0; a second one-word request with nwords=0 behaves identically (treated as 1).
- Three-word sub 0x0..0_00000000_00000000 - 0x0..0_00000000_00000001 with res_ready_i low for 3 cycles mid-stream -> words 0xFFFFFFFF x3, C=0, S=1, Z=0. opr_ready_o stays low while the output register is full, and no word is lost or duplicated.
- Back-to-back streaming with res_ready_i=1 and opr_valid_i=1 -> one result per cycle. req_valid_i asserted during RUN is not accepted until after done_o.
- rst asserted during RUN after one of four words -> next cycle state is IDLE, res_valid_o=0, req_ready_o=1, no done_o. A following 1-word add produces correct flags (carry not stale).

Source files
------------

// File: rtl/exec_addx_seq_pkg.sv
// ----------------------------------------------------------------------------
// exec_addx_seq_pkg
// Shared widths, flag bit positions, adder mode encodings and sequencer state
// encodings for the multi-precision add/subtract sequencer and its word adder.
// Helper functions:
//   pack_flags    - assemble {V, S, Z, C} into a flags word by bit index
//   clamp_nwords  - a word count of zero is treated as one word
// ----------------------------------------------------------------------------
package exec_addx_seq_pkg;

    localparam int W_OPR   = 32;
    localparam int W_FLAGS = 4;
    localparam int W_CNT   = 4;

    // Flag bit positions inside a W_FLAGS flags word, ordered {V, S, Z, C}
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 3;

    // Word-adder mode select: bit 1 = use incoming carry, bit 0 = subtract
    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b01;
    localparam logic [1:0] SEL_ADC = 2'b10;
    localparam logic [1:0] SEL_SBB = 2'b11;

    localparam logic [W_CNT-1:0] CNT_ONE = {{(W_CNT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    function automatic logic [W_FLAGS-1:0] pack_flags(
        input logic v,
        input logic s,
        input logic z,
        input logic c
    );
        logic [W_FLAGS-1:0] f;
        f         = {W_FLAGS{1'b0}};
        f[FLAG_V] = v;
        f[FLAG_S] = s;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        return f;
    endfunction

    function automatic logic [W_CNT-1:0] clamp_nwords(input logic [W_CNT-1:0] n);
        logic [W_CNT-1:0] r;
        if (n == {W_CNT{1'b0}}) begin
            r = CNT_ONE;
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/exec_addx_seq_exec_addx.sv
// ----------------------------------------------------------------------------
// exec_addx
// Single-word combinational adder/subtractor with optional carry chaining.
// Subtraction is A + ~B + carry-in; the carry-out is the raw adder carry, so
// for subtraction C = 1 means "no borrow".
// In chained modes (i_select[1] = 1) the carry input flag is interpreted as
// a carry for add and as a borrow for subtract, which is why the effective
// carry-in is i_flags[C] ^ i_select[0].
// Ports:
//   i_opr0   [W_OPR]    A word
//   i_opr1   [W_OPR]    B word
//   i_select [2]        {chain, sub}
//   i_flags  [W_FLAGS]  incoming flags; only the C bit is consumed
//   o_res    [W_OPR]    result word
//   o_flags  [W_FLAGS]  {V, S, Z, C} for this word
// ----------------------------------------------------------------------------
module exec_addx
    import exec_addx_seq_pkg::*;
(
    input  logic [W_OPR-1:0]   i_opr0,
    input  logic [W_OPR-1:0]   i_opr1,
    input  logic [1:0]         i_select,
    input  logic [W_FLAGS-1:0] i_flags,
    output logic [W_OPR-1:0]   o_res,
    output logic [W_FLAGS-1:0] o_flags
);

    logic [W_OPR-1:0] w_b_eff;
    logic             w_cin;
    logic [W_OPR:0]   w_sum;
    logic             w_v;
    logic             w_unused_flags;

    // Only the carry bit of the incoming flags takes part in the sum
    assign w_unused_flags = ^i_flags[W_FLAGS-1:1];

    // Word sum with carry taken from bit W_OPR, plus per-word flags
    always_comb begin
        w_b_eff = {W_OPR{1'b0}};
        w_cin   = 1'b0;
        w_sum   = {(W_OPR+1){1'b0}};
        w_v     = 1'b0;
        if (i_select[0]) begin
            w_b_eff = ~i_opr1;
        end else begin
            w_b_eff = i_opr1;
        end
        if (i_select[1]) begin
            w_cin = i_flags[FLAG_C] ^ i_select[0];
        end else begin
            w_cin = i_select[0];
        end
        w_sum = {1'b0, i_opr0} + {1'b0, w_b_eff} + {{W_OPR{1'b0}}, w_cin};
        // Signed overflow: operands of equal sign produce a result of the other sign
        w_v   = (i_opr0[W_OPR-1] == w_b_eff[W_OPR-1]) &&
                (w_sum[W_OPR-1] != i_opr0[W_OPR-1]);
    end

    assign o_res   = w_sum[W_OPR-1:0];
    assign o_flags = pack_flags(w_v, w_sum[W_OPR-1],
                                (w_sum[W_OPR-1:0] == {W_OPR{1'b0}}),
                                w_sum[W_OPR]);

endmodule

// File: rtl/exec_addx_seq.sv
// ----------------------------------------------------------------------------
// exec_addx_seq
// Multi-precision add/subtract sequencer. Accepts one request (add/sub, N
// words), consumes N operand pairs least-significant first, chains carry or
// borrow between words through exec_addx, streams out N result words through
// a one-entry output register and posts {V, S, Z, C} for the whole result.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid_i    request offered          req_ready_o  high only in IDLE
//   req_sub_i      0 = A+B, 1 = A-B         req_nwords_i word count (0 -> 1)
//   opr_valid_i    operand pair offered     opr_ready_o  operand pair accepted
//   opr0_i, opr1_i A and B words
//   res_valid_o    result word valid        res_ready_i  consumer accepts word
//   res_o          result word              res_last_o   most-significant word
//   done_o         one-cycle pulse after the last word is accepted
//   flags_o        final {V, S, Z, C}, held until the next operation ends
// ----------------------------------------------------------------------------
module exec_addx_seq
    import exec_addx_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_sub_i,
    input  logic [W_CNT-1:0]   req_nwords_i,
    input  logic               opr_valid_i,
    output logic               opr_ready_o,
    input  logic [W_OPR-1:0]   opr0_i,
    input  logic [W_OPR-1:0]   opr1_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [W_OPR-1:0]   res_o,
    output logic               res_last_o,
    output logic               done_o,
    output logic [W_FLAGS-1:0] flags_o
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_sub;
    logic [W_CNT-1:0]   r_remaining;
    logic               r_carry;
    logic               r_zacc;
    logic               r_res_valid;
    logic [W_OPR-1:0]   r_res;
    logic               r_res_last;
    logic               r_done;
    logic [W_FLAGS-1:0] r_flags;
    logic [W_FLAGS-1:0] r_flags_pend;

    logic               w_req_ready;
    logic               w_opr_ready;
    logic               w_opr_hs;
    logic               w_res_hs;
    logic               w_last_word;

    logic [1:0]         w_add_sel;
    logic [W_FLAGS-1:0] w_add_flags_in;
    logic [W_OPR-1:0]   w_add_res;
    logic [W_FLAGS-1:0] w_add_flags;

    // Carry register holds a raw carry; the adder wants a borrow for subtract
    assign w_add_sel      = {1'b1, r_sub};
    assign w_add_flags_in = {{(W_FLAGS-1){1'b0}}, r_carry ^ r_sub};

    exec_addx u_exec_addx (
        .i_opr0   (opr0_i),
        .i_opr1   (opr1_i),
        .i_select (w_add_sel),
        .i_flags  (w_add_flags_in),
        .o_res    (w_add_res),
        .o_flags  (w_add_flags)
    );

    assign w_opr_hs    = opr_valid_i & w_opr_ready;
    assign w_res_hs    = r_res_valid & res_ready_i;
    assign w_last_word = (r_remaining == CNT_ONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake-ready decode
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_opr_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid_i) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                // One-entry output register: accept when empty or being drained now
                w_opr_ready = ~r_res_valid | res_ready_i;
                if (w_opr_ready && opr_valid_i && w_last_word) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_res_hs && r_res_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operation context, carry/zero chain, output register and final flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub        <= 1'b0;
            r_remaining  <= {W_CNT{1'b0}};
            r_carry      <= 1'b0;
            r_zacc       <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res        <= {W_OPR{1'b0}};
            r_res_last   <= 1'b0;
            r_done       <= 1'b0;
            r_flags      <= {W_FLAGS{1'b0}};
            r_flags_pend <= {W_FLAGS{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_sub       <= req_sub_i;
                        r_remaining <= clamp_nwords(req_nwords_i);
                        // First subtract word needs +1 to complete the two's complement of B
                        r_carry     <= req_sub_i;
                        r_zacc      <= 1'b1;
                    end else begin
                        r_remaining <= r_remaining;
                    end
                end
                ST_RUN: begin
                    if (w_opr_hs) begin
                        r_res       <= w_add_res;
                        r_res_valid <= 1'b1;
                        r_res_last  <= w_last_word;
                        r_carry     <= w_add_flags[FLAG_C];
                        r_zacc      <= r_zacc & w_add_flags[FLAG_Z];
                        r_remaining <= r_remaining - CNT_ONE;
                        if (w_last_word) begin
                            // V and S come from the top word only; Z covers every word
                            r_flags_pend <= pack_flags(w_add_flags[FLAG_V],
                                                       w_add_flags[FLAG_S],
                                                       r_zacc & w_add_flags[FLAG_Z],
                                                       w_add_flags[FLAG_C]);
                        end else begin
                            r_flags_pend <= r_flags_pend;
                        end
                    end else if (w_res_hs) begin
                        r_res_valid <= 1'b0;
                    end else begin
                        r_res_valid <= r_res_valid;
                    end
                end
                ST_DRAIN: begin
                    if (w_res_hs) begin
                        r_res_valid <= 1'b0;
                        if (r_res_last) begin
                            r_flags <= r_flags_pend;
                            r_done  <= 1'b1;
                        end else begin
                            r_flags <= r_flags;
                        end
                    end else begin
                        r_res_valid <= r_res_valid;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = w_req_ready;
    assign opr_ready_o = w_opr_ready;
    assign res_valid_o = r_res_valid;
    assign res_o       = r_res;
    assign res_last_o  = r_res_last;
    assign done_o      = r_done;
    assign flags_o     = r_flags;

endmodule

// File: tb/tb_exec_addx_seq.sv
// ----------------------------------------------------------------------------
// tb_exec_addx_seq
// Directed stimulus with hand-computed expected words and flags pushed into
// scoreboard queues; a negedge monitor pops and compares whenever a result
// word is handed over or done_o pulses.
// ----------------------------------------------------------------------------
module tb_exec_addx_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_sub_i;
    logic [3:0]  req_nwords_i;
    logic        opr_valid_i;
    logic        opr_ready_o;
    logic [31:0] opr0_i;
    logic [31:0] opr1_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_o;
    logic        res_last_o;
    logic        done_o;
    logic [3:0]  flags_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] exp_words[$];
    logic [3:0]  exp_flags[$];

    exec_addx_seq dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_sub_i    (req_sub_i),
        .req_nwords_i (req_nwords_i),
        .opr_valid_i  (opr_valid_i),
        .opr_ready_o  (opr_ready_o),
        .opr0_i       (opr0_i),
        .opr1_i       (opr1_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_o        (res_o),
        .res_last_o   (res_last_o),
        .done_o       (done_o),
        .flags_o      (flags_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic push_word(input logic [31:0] d, input logic last);
        exp_words.push_back({last, d});
    endtask

    // Monitor: compare each consumed result word and each done pulse
    always @(negedge clk) begin
        logic [32:0] ew;
        logic [3:0]  ef;
        if (!rst) begin
            if (res_valid_o && res_ready_i) begin
                if (exp_words.size() == 0) begin
                    fail_now("unexpected_word");
                end else begin
                    ew = exp_words.pop_front();
                    check("res_word", {32'd0, res_o}, {32'd0, ew[31:0]});
                    check("res_last", {63'd0, res_last_o}, {63'd0, ew[32]});
                end
            end
            if (done_o) begin
                if (exp_flags.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    ef = exp_flags.pop_front();
                    check("flags", {60'd0, flags_o}, {60'd0, ef});
                end
            end
        end
    end

    task automatic send_req(input logic sub, input logic [3:0] n);
        int k;
        k = 0;
        req_sub_i    = sub;
        req_nwords_i = n;
        req_valid_i  = 1'b1;
        @(negedge clk);
        while (!req_ready_o && k < 200) begin
            k++;
            @(negedge clk);
        end
        if (!req_ready_o) fail_now("req_timeout");
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic send_opr(input logic [31:0] a, input logic [31:0] b, output int stalls);
        stalls      = 0;
        opr0_i      = a;
        opr1_i      = b;
        opr_valid_i = 1'b1;
        @(negedge clk);
        while (!opr_ready_o && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (!opr_ready_o) fail_now("opr_timeout");
        @(posedge clk);
        #1;
        opr_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (!(req_ready_o && exp_words.size() == 0 && exp_flags.size() == 0) && k < 300) begin
            k++;
            @(negedge clk);
        end
        if (k >= 300) fail_now("idle_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        int stall_sum;
        rst          = 1'b1;
        req_valid_i  = 1'b0;
        req_sub_i    = 1'b0;
        req_nwords_i = 4'd0;
        opr_valid_i  = 1'b0;
        opr0_i       = 32'd0;
        opr1_i       = 32'd0;
        res_ready_i  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", {63'd0, res_valid_o}, 64'd0);
        check("rst_res",       {32'd0, res_o},       64'd0);
        check("rst_res_last",  {63'd0, res_last_o},  64'd0);
        check("rst_done",      {63'd0, done_o},      64'd0);
        check("rst_flags",     {60'd0, flags_o},     64'd0);
        check("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
        check("rst_opr_ready", {63'd0, opr_ready_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two-word add with carry across words
        push_word(32'h00000000, 1'b0);
        push_word(32'h00000002, 1'b1);
        exp_flags.push_back(4'b0000);
        send_req(1'b0, 4'd2);
        send_opr(32'hFFFFFFFF, 32'h00000001, st);
        send_opr(32'h00000001, 32'h00000000, st);
        wait_idle();

        // Two-word subtract of equal operands
        push_word(32'h00000000, 1'b0);
        push_word(32'h00000000, 1'b1);
        exp_flags.push_back(4'b0011);
        send_req(1'b1, 4'd2);
        send_opr(32'h9ABCDEF0, 32'h9ABCDEF0, st);
        send_opr(32'h12345678, 32'h12345678, st);
        wait_idle();

        // One-word signed overflow, then the same with nwords = 0
        push_word(32'h80000000, 1'b1);
        exp_flags.push_back(4'b1100);
        send_req(1'b0, 4'd1);
        send_opr(32'h7FFFFFFF, 32'h00000001, st);
        wait_idle();
        push_word(32'h80000000, 1'b1);
        exp_flags.push_back(4'b1100);
        send_req(1'b0, 4'd0);
        send_opr(32'h7FFFFFFF, 32'h00000001, st);
        wait_idle();

        // Three-word subtract 0 - 1 with the consumer stalled mid-stream
        push_word(32'hFFFFFFFF, 1'b0);
        push_word(32'hFFFFFFFF, 1'b0);
        push_word(32'hFFFFFFFF, 1'b1);
        exp_flags.push_back(4'b0100);
        send_req(1'b1, 4'd3);
        fork
            begin
                send_opr(32'h00000000, 32'h00000001, st);
                send_opr(32'h00000000, 32'h00000000, st);
                send_opr(32'h00000000, 32'h00000000, st);
            end
            begin
                int k;
                k = 0;
                @(posedge clk);
                #1;
                while (!res_valid_o && k < 50) begin
                    k++;
                    @(posedge clk);
                    #1;
                end
                res_ready_i = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_opr_ready", {63'd0, opr_ready_o}, 64'd0);
                    @(posedge clk);
                    #1;
                end
                res_ready_i = 1'b1;
            end
        join
        wait_idle();

        // Four-word back-to-back add; a request held during RUN waits for done
        push_word(32'h00000000, 1'b0);
        push_word(32'h00000031, 1'b0);
        push_word(32'h00000000, 1'b0);
        push_word(32'h80000001, 1'b1);
        exp_flags.push_back(4'b1100);
        push_word(32'h00000000, 1'b1);
        exp_flags.push_back(4'b0011);
        send_req(1'b0, 4'd4);
        stall_sum = 0;
        fork
            begin
                send_opr(32'h80000000, 32'h80000000, st); stall_sum += st;
                send_opr(32'h00000010, 32'h00000020, st); stall_sum += st;
                send_opr(32'hFFFFFFFF, 32'h00000001, st); stall_sum += st;
                send_opr(32'h40000000, 32'h40000000, st); stall_sum += st;
            end
            begin
                int k;
                k = 0;
                req_sub_i    = 1'b0;
                req_nwords_i = 4'd1;
                req_valid_i  = 1'b1;
                @(negedge clk);
                while (!req_ready_o && k < 100) begin
                    k++;
                    @(negedge clk);
                end
                check("req_wait_done", {63'd0, done_o}, 64'd1);
                @(posedge clk);
                #1;
                req_valid_i = 1'b0;
            end
        join
        check("b2b_stalls", 64'(stall_sum), 64'd0);
        send_opr(32'h00000005, 32'hFFFFFFFB, st);
        wait_idle();

        // Reset after one of four words: abort with no done, then a clean add
        send_req(1'b0, 4'd4);
        res_ready_i = 1'b0;
        send_opr(32'hFFFFFFFF, 32'h00000001, st);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_req_ready", {63'd0, req_ready_o}, 64'd1);
        check("abort_res_valid", {63'd0, res_valid_o}, 64'd0);
        check("abort_done",      {63'd0, done_o},      64'd0);
        @(posedge clk);
        #1;
        res_ready_i = 1'b1;
        push_word(32'h00000008, 1'b1);
        exp_flags.push_back(4'b0000);
        send_req(1'b0, 4'd1);
        send_opr(32'h00000005, 32'h00000003, st);
        wait_idle();

        check("words_left", 64'(exp_words.size()), 64'd0);
        check("flags_left", 64'(exp_flags.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
